// File: rtl/ptw_responder.sv
// Page-table-walk responder: a small tag-matched translation table that answers
// one walk request at a time after a fixed latency and keeps hit/miss statistics.

module ptw_entry (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic        clr,
  input  logic [26:0] wr_vpn,
  input  logic [28:0] wr_data,
  input  logic [26:0] lk_vpn,
  output logic        match,
  output logic [28:0] data
);
  logic        valid;
  logic [26:0] vpn;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   valid <= 1'b0;
    else if (clr) valid <= 1'b0;
    else if (we)  valid <= 1'b1;

  // payload is only observable through a valid tag match, so it needs no reset
  always_ff @(posedge clk)
    if (we && !clr) begin
      vpn  <= wr_vpn;
      data <= wr_data;
    end

  assign match = valid && (vpn == lk_vpn);
endmodule

module ptw_responder #(
  parameter int ENTRIES  = 8,
  parameter int WALK_LAT = 4,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             io_requestor_x_req_ready,
  input  logic             io_requestor_x_req_valid,
  input  logic [26:0]      io_requestor_x_req_bits_bits_addr,
  output logic             io_requestor_x_resp_valid,
  output logic             io_requestor_x_resp_bits_ae,
  output logic [53:0]      io_requestor_x_resp_bits_pte_ppn,
  output logic             io_requestor_x_resp_bits_pte_d,
  output logic             io_requestor_x_resp_bits_pte_a,
  output logic             io_requestor_x_resp_bits_pte_g,
  output logic             io_requestor_x_resp_bits_pte_u,
  output logic             io_requestor_x_resp_bits_pte_x,
  output logic             io_requestor_x_resp_bits_pte_w,
  output logic             io_requestor_x_resp_bits_pte_r,
  output logic             io_requestor_x_resp_bits_pte_v,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [26:0]      cfg_vpn,
  input  logic [19:0]      cfg_ppn,
  input  logic [7:0]       cfg_perm,
  input  logic             cfg_ae,
  input  logic             cfg_clr,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt
);
  typedef struct packed {
    logic        ae;
    logic [19:0] ppn;
    logic [7:0]  perm;   // {d,a,g,u,x,w,r,v}
  } pte_t;

  typedef enum logic [1:0] {IDLE, WALK, RESP} state_t;

  state_t                   state, nxt;
  logic [3:0]               cnt;
  logic                     ready_q, hs;
  logic [15:0]              hit_q, miss_q;
  logic [ENTRIES-1:0]       match;
  logic [ENTRIES-1:0][28:0] ent_data;
  pte_t                     lk, res, out;

  assign hs = io_requestor_x_req_valid && ready_q;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    ptw_entry u_ent (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (cfg_we && (cfg_idx == IDX_W'(i))),
      .clr    (cfg_clr),
      .wr_vpn (cfg_vpn),
      .wr_data({cfg_ae, cfg_ppn, cfg_perm}),
      .lk_vpn (io_requestor_x_req_bits_bits_addr),
      .match  (match[i]),
      .data   (ent_data[i])
    );
  end

  // descending scan so the lowest matching index wins
  always_comb begin
    lk = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (match[i]) lk = ent_data[i];
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (hs) nxt = (WALK_LAT == 1) ? RESP : WALK;
      WALK:    if (cnt == 4'd1) nxt = RESP;   // counter reaches 0 as RESP is entered
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      cnt     <= '0;
      res     <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state   <= nxt;
      ready_q <= (nxt == IDLE);
      if (hs) begin
        cnt <= 4'(WALK_LAT - 1);
        res <= lk;
      end else if (state == WALK && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == RESP) begin
        if (res.perm[0]) begin
          if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
        end else if (miss_q != 16'hFFFF) begin
          miss_q <= miss_q + 16'd1;
        end
      end
    end

  assign out = (state == RESP) ? res : pte_t'('0);

  assign io_requestor_x_req_ready        = ready_q;
  assign io_requestor_x_resp_valid       = (state == RESP);
  assign io_requestor_x_resp_bits_ae     = out.ae;
  assign io_requestor_x_resp_bits_pte_ppn = {34'd0, out.ppn};
  assign {io_requestor_x_resp_bits_pte_d, io_requestor_x_resp_bits_pte_a,
          io_requestor_x_resp_bits_pte_g, io_requestor_x_resp_bits_pte_u,
          io_requestor_x_resp_bits_pte_x, io_requestor_x_resp_bits_pte_w,
          io_requestor_x_resp_bits_pte_r, io_requestor_x_resp_bits_pte_v} = out.perm;
  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
endmodule
